mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port unified memory between the IF stage (instruction read) and the MEM stage (LW/SW).
//  Sits between pipeline stages and memory; drives IF/MEM stall lines consumed by the hazard logic.
//  Data accesses have priority. A streak limiter prevents fetch starvation. A timeout aborts hung accesses.
// PARAMETERS
//  ADDR_W       32  address width
//  DATA_W       32  data width
//  MAX_STREAK   4   consecutive data grants allowed while if_req waits; next grant goes to IF
//  TIMEOUT      64  busy cycles without m_ready before abort
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       synchronous, active-high
//  if_req     in   1       fetch request (level), held until if_valid
//  if_addr    in   ADDR_W  fetch address, stable while if_req
//  if_rdata   out  DATA_W  fetched instruction, valid with if_valid
//  if_valid   out  1       1-cycle pulse: fetch complete
//  d_rd       in   1       MemRead from controller (level)
//  d_wr       in   1       MemWrite from controller (level)
//  d_addr     in   ADDR_W  data address (ALU result)
//  d_wdata    in   DATA_W  store data
//  d_rdata    out  DATA_W  load data, valid with d_valid
//  d_valid    out  1       1-cycle pulse: load/store complete
//  m_req      out  1       memory request, held until m_ready
//  m_we       out  1       1 = write
//  m_addr     out  ADDR_W  memory address
//  m_wdata    out  DATA_W  memory write data
//  m_rdata    in   DATA_W  memory read data, valid with m_ready
//  m_ready    in   1       memory completes current access this cycle
//  stall_if   out  1       if_req & ~if_valid (combinational)
//  stall_mem  out  1       (d_rd|d_wr) & ~d_valid (combinational)
//  err        out  1       1-cycle pulse on timeout abort
// BEHAVIOUR
//  Reset: state=IDLE; m_req, m_we, if_valid, d_valid, err = 0; m_addr, m_wdata, if_rdata, d_rdata = 0; streak = 0; timer = 0.
//  FSM states: IDLE, D_BUSY, I_BUSY. All m_* outputs are registered.
//  IDLE: if data request pending and not (if_req & streak==MAX_STREAK) -> latch d_addr/d_wdata, m_we=d_wr, m_req=1, go to D_BUSY.
//        Otherwise, if if_req -> latch if_addr, m_we=0, m_req=1, go to I_BUSY. Otherwise stay.
//  d_rd & d_wr both high: treat as a write (m_we=1). No load data is returned.
//  Streak: +1 on each data grant while if_req=1; saturates at MAX_STREAK; cleared on IF grant or when if_req=0 at a data grant.
//  BUSY: m_req stays 1 and m_addr/m_we/m_wdata stay constant until m_ready. Timer increments each BUSY cycle.
//  m_ready in BUSY: m_req=0 on the next edge; the matching valid pulses for exactly 1 cycle; if_rdata or d_rdata <= m_rdata (load or fetch only).
//        Next state is IDLE. There is one mandatory turnaround cycle, so minimum latency is request to valid = 2 cycles for m_ready tied high.
//  Timeout: when timer==TIMEOUT-1 with no m_ready -> drop m_req, pulse err and the matching valid; rdata becomes all-ones; go to IDLE.
//  m_ready in IDLE is ignored. Requests that drop mid-access are ignored: the access completes and valid still pulses.
//  rdata outputs hold their value between completions. Reset mid-access: abandon immediately; no valid pulse.
// TESTING
//  m_ready=1 always; if_req alone, if_addr=0x100, m_rdata=0x00500093 -> m_req at cycle 1, if_valid at cycle 2 with if_rdata=0x00500093.
//  if_req and d_rd both high in IDLE, d_addr=0x2000 -> data granted first (m_addr=0x2000, m_we=0); IF granted after d_valid.
//  d_wr=1, d_addr=0x40, d_wdata=0xDEADBEEF, m_ready delayed 5 cycles -> m_req/m_we/m_addr/m_wdata stable 5 cycles; stall_mem=1 until the d_valid pulse.
//  if_req held while d_rd held continuously -> after 4 data grants, the 5th grant goes to IF; the streak then restarts.
//  m_ready never asserted -> err and d_valid pulse after 64 busy cycles, d_rdata=0xFFFFFFFF, state returns to IDLE.
//  reset asserted in D_BUSY -> next cycle m_req=0, no d_valid, state IDLE; a new request is served normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the fetch port, the data port, the memory port and the status lines
//   of the unified-memory arbiter.
//   master : the arbiter's view (takes pipeline/memory inputs, drives m_*, valids, stalls, err)
//   slave  : the pipeline + memory view (the mirror image)
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              d_rd;
  logic              d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              m_ready;
  logic              stall_if;
  logic              stall_mem;
  logic              err;

  modport master (
    input  if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, m_rdata, m_ready,
    output if_rdata, if_valid, d_rdata, d_valid, m_req, m_we, m_addr, m_wdata,
           stall_if, stall_mem, err
  );

  modport slave (
    output if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, m_rdata, m_ready,
    input  if_rdata, if_valid, d_rdata, d_valid, m_req, m_we, m_addr, m_wdata,
           stall_if, stall_mem, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between instruction fetch (IF) and load/store (MEM).
//   Data accesses win, except that after MAX_STREAK data grants in a row with a fetch
//   waiting, the next grant goes to the fetch. A busy access that sees no m_ready for
//   TIMEOUT cycles is aborted with err and an all-ones read result.
// Ports
//   clk    : clock, rising edge
//   reset  : synchronous, active-high
//   bus    : mem_port_arbiter_if.master (fetch port, data port, memory port, stalls, err)
//
// state  | meaning
// IDLE   | no access in flight; arbitration happens here (also the turnaround cycle)
// D_BUSY | data access (load/store) outstanding on the memory port
// I_BUSY | instruction fetch outstanding on the memory port
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 64
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.master bus
);

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, D_BUSY, I_BUSY} state_t;

  state_t            state, state_n;
  logic              m_req_q, m_req_n;
  logic              m_we_q, m_we_n;
  logic [ADDR_W-1:0] m_addr_q, m_addr_n;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_n;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_n;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_n;
  logic              if_valid_q, if_valid_n;
  logic              d_valid_q, d_valid_n;
  logic              err_q, err_n;
  logic [SW-1:0]     streak_q, streak_n;
  logic [TW-1:0]     timer_q, timer_n;
  logic              d_req;

  assign d_req = bus.d_rd | bus.d_wr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      err_q      <= 1'b0;
      streak_q   <= '0;
      timer_q    <= '0;
    end else begin
      state      <= state_n;
      m_req_q    <= m_req_n;
      m_we_q     <= m_we_n;
      m_addr_q   <= m_addr_n;
      m_wdata_q  <= m_wdata_n;
      if_rdata_q <= if_rdata_n;
      d_rdata_q  <= d_rdata_n;
      if_valid_q <= if_valid_n;
      d_valid_q  <= d_valid_n;
      err_q      <= err_n;
      streak_q   <= streak_n;
      timer_q    <= timer_n;
    end
  end

  always_comb begin
    state_n    = state;
    m_req_n    = m_req_q;
    m_we_n     = m_we_q;
    m_addr_n   = m_addr_q;
    m_wdata_n  = m_wdata_q;
    if_rdata_n = if_rdata_q;
    d_rdata_n  = d_rdata_q;
    if_valid_n = 1'b0;
    d_valid_n  = 1'b0;
    err_n      = 1'b0;
    streak_n   = streak_q;
    timer_n    = timer_q;

    case (state)
      IDLE: begin
        if (d_req && !(bus.if_req && streak_q == STREAK_MAX)) begin
          state_n   = D_BUSY;
          m_req_n   = 1'b1;
          m_we_n    = bus.d_wr;   // rd+wr together is treated as a store
          m_addr_n  = bus.d_addr;
          m_wdata_n = bus.d_wdata;
          timer_n   = '0;
          // the streak only counts grants that actually made a fetch wait
          if (!bus.if_req)
            streak_n = '0;
          else if (streak_q != STREAK_MAX)
            streak_n = streak_q + 1'b1;
        end else if (bus.if_req) begin
          state_n  = I_BUSY;
          m_req_n  = 1'b1;
          m_we_n   = 1'b0;
          m_addr_n = bus.if_addr;
          timer_n  = '0;
          streak_n = '0;
        end
      end

      D_BUSY, I_BUSY: begin
        if (bus.m_ready) begin
          state_n = IDLE;
          m_req_n = 1'b0;
          if (state == I_BUSY) begin
            if_valid_n = 1'b1;
            if_rdata_n = bus.m_rdata;
          end else begin
            d_valid_n = 1'b1;
            if (!m_we_q)
              d_rdata_n = bus.m_rdata;
          end
        end else if (timer_q == TIMER_LAST) begin
          // abort: release the pipeline with a poisoned result
          state_n = IDLE;
          m_req_n = 1'b0;
          err_n   = 1'b1;
          if (state == I_BUSY) begin
            if_valid_n = 1'b1;
            if_rdata_n = '1;
          end else begin
            d_valid_n = 1'b1;
            d_rdata_n = '1;
          end
        end else begin
          timer_n = timer_q + 1'b1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign bus.m_req     = m_req_q;
  assign bus.m_we      = m_we_q;
  assign bus.m_addr    = m_addr_q;
  assign bus.m_wdata   = m_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.err       = err_q;
  assign bus.stall_if  = bus.if_req & ~if_valid_q;
  assign bus.stall_mem = d_req & ~d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_STREAK(4), .TIMEOUT(64)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t q_if[$];
  exp_t q_d[$];
  exp_t mon_e;

  typedef struct {
    logic        fetch;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    int          delay;
    logic        exp_we;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // scoreboard side: pop on every valid pulse
  always @(negedge clk) begin
    if (bus.if_valid) begin
      checks++;
      if (q_if.size() == 0) begin
        errors++;
        $display("FAIL if_valid_unexpected actual=1 required=0");
      end else begin
        mon_e = q_if.pop_front();
        if (bus.if_rdata !== mon_e.rdata || bus.err !== mon_e.err) begin
          errors++;
          $display("FAIL if_result actual=%h/err%b required=%h/err%b",
                   bus.if_rdata, bus.err, mon_e.rdata, mon_e.err);
        end
      end
    end
    if (bus.d_valid) begin
      checks++;
      if (q_d.size() == 0) begin
        errors++;
        $display("FAIL d_valid_unexpected actual=1 required=0");
      end else begin
        mon_e = q_d.pop_front();
        if (bus.d_rdata !== mon_e.rdata || bus.err !== mon_e.err) begin
          errors++;
          $display("FAIL d_result actual=%h/err%b required=%h/err%b",
                   bus.d_rdata, bus.err, mon_e.rdata, mon_e.err);
        end
      end
    end
    if (bus.err) begin
      checks++;
      if (!bus.if_valid && !bus.d_valid) begin
        errors++;
        $display("FAIL err_without_valid actual=err1 required=err0");
      end
    end
  end

  task automatic idle_inputs();
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_rd    = 1'b0;
    bus.d_wr    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.m_ready = 1'b0;
  endtask

  vec_t v;
  logic bad;

  initial begin
    //            fetch rd  wr  addr          wdata         mrdata        dly we  exp_rdata
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0,        32'h0050_0093, 0, 1'b0, 32'h0050_0093};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0000_2000, 32'h0,        32'h1234_5678, 0, 1'b0, 32'h1234_5678};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h1111_1111, 5, 1'b1, 32'h1234_5678};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h0000_0044, 32'hCAFE_F00D, 32'h2222_2222, 2, 1'b1, 32'h1234_5678};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h0000_0104, 32'h0,        32'h00A0_0113, 3, 1'b0, 32'h00A0_0113};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h0000_0080, 32'h0,        32'hA5A5_5A5A, 1, 1'b0, 32'hA5A5_5A5A};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,        32'h0000_0000, 0, 1'b0, 32'h0000_0000};

    reset = 1'b1;
    idle_inputs();
    bus.m_rdata = '0;
    repeat (3) @(negedge clk);
    check("reset_mport", {bus.m_req, bus.m_we, bus.m_addr, 30'h0}, 64'h0);
    check("reset_mwdata", {32'h0, bus.m_wdata}, 64'h0);
    check("reset_rdata", {bus.if_rdata, bus.d_rdata}, 64'h0);
    check("reset_pulses", {61'h0, bus.if_valid, bus.d_valid, bus.err}, 64'h0);
    reset = 1'b0;

    // m_ready while idle must not produce anything
    bus.m_ready = 1'b1;
    bus.m_rdata = 32'h0BAD_0BAD;
    repeat (2) @(negedge clk);
    check("idle_ready_ignored", {61'h0, bus.m_req, bus.if_valid, bus.d_valid}, 64'h0);
    bus.m_ready = 1'b0;
    @(negedge clk);

    // single transactions
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      bus.if_req  = v.fetch;
      bus.if_addr = v.fetch ? v.addr : 32'h0;
      bus.d_rd    = v.rd;
      bus.d_wr    = v.wr;
      bus.d_addr  = v.fetch ? 32'h0 : v.addr;
      bus.d_wdata = v.wdata;
      bus.m_rdata = v.mrdata;
      bus.m_ready = (v.delay == 0);
      if (v.fetch) q_if.push_back('{v.exp_rdata, 1'b0});
      else         q_d.push_back('{v.exp_rdata, 1'b0});
      @(negedge clk);
      check($sformatf("v%0d_grant", i), {bus.m_req, bus.m_we, bus.m_addr}, {1'b1, v.exp_we, v.addr});
      if (v.exp_we) check($sformatf("v%0d_wdata", i), bus.m_wdata, v.wdata);
      bad = 1'b0;
      for (int k = 0; k < v.delay; k++) begin
        @(negedge clk);
        if (bus.m_req !== 1'b1 || bus.m_we !== v.exp_we || bus.m_addr !== v.addr ||
            (v.exp_we && bus.m_wdata !== v.wdata) || bus.if_valid || bus.d_valid)
          bad = 1'b1;
        if ((v.fetch ? bus.stall_if : bus.stall_mem) !== 1'b1) bad = 1'b1;
      end
      if (v.delay > 0) check($sformatf("v%0d_hold_stable", i), {63'h0, bad}, 64'h0);
      bus.m_ready = 1'b1;
      check($sformatf("v%0d_stall_busy", i), {63'h0, v.fetch ? bus.stall_if : bus.stall_mem}, 64'h1);
      @(negedge clk);
      check($sformatf("v%0d_done", i),
            {61'h0, v.fetch ? bus.if_valid : bus.d_valid, bus.m_req,
             v.fetch ? bus.stall_if : bus.stall_mem}, {61'h0, 3'b100});
      idle_inputs();
      @(negedge clk);
      check($sformatf("v%0d_pulse_1cyc", i), {62'h0, bus.if_valid | bus.d_valid, bus.m_req}, 64'h0);
    end

    // data beats fetch when both arrive together; fetch follows after a turnaround
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0300;
    bus.d_rd    = 1'b1;
    bus.d_addr  = 32'h0000_2000;
    bus.m_rdata = 32'h5555_AAAA;
    bus.m_ready = 1'b1;
    q_d.push_back('{32'h5555_AAAA, 1'b0});
    q_if.push_back('{32'h5555_AAAA, 1'b0});
    @(negedge clk);
    check("prio_data_first", {bus.m_req, bus.m_we, bus.m_addr}, {1'b1, 1'b0, 32'h0000_2000});
    check("prio_stall_if", {63'h0, bus.stall_if}, 64'h1);
    @(negedge clk);
    check("prio_turnaround", {62'h0, bus.d_valid, bus.m_req}, 64'h2);
    bus.d_rd = 1'b0;
    @(negedge clk);
    check("prio_if_second", {bus.m_req, bus.m_we, bus.m_addr}, {1'b1, 1'b0, 32'h0000_0300});
    @(negedge clk);
    check("prio_if_valid", {63'h0, bus.if_valid}, 64'h1);
    idle_inputs();
    @(negedge clk);

    // streak limiter: fetch wins every fifth grant under continuous data pressure
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0200;
    bus.d_rd    = 1'b1;
    bus.d_addr  = 32'h0000_1000;
    bus.m_rdata = 32'h0000_0077;
    bus.m_ready = 1'b1;
    for (int g = 0; g < 10; g++) begin
      @(negedge clk);
      check($sformatf("streak_grant%0d", g), bus.m_addr,
            (g % 5 == 4) ? 32'h0000_0200 : 32'h0000_1000);
      if (g % 5 == 4) q_if.push_back('{32'h0000_0077, 1'b0});
      else            q_d.push_back('{32'h0000_0077, 1'b0});
      @(negedge clk);
    end
    idle_inputs();
    @(negedge clk);

    // timeout on a load that never completes
    bus.d_rd    = 1'b1;
    bus.d_addr  = 32'h0000_0060;
    bus.m_ready = 1'b0;
    q_d.push_back('{32'hFFFF_FFFF, 1'b1});
    @(negedge clk);
    check("tmo_grant", {bus.m_req, bus.m_addr}, {1'b1, 32'h0000_0060});
    bad = 1'b0;
    for (int i = 1; i < 64; i++) begin
      @(negedge clk);
      if (bus.m_req !== 1'b1 || bus.err || bus.d_valid) bad = 1'b1;
    end
    check("tmo_no_early_abort", {63'h0, bad}, 64'h0);
    @(negedge clk);
    check("tmo_abort", {61'h0, bus.err, bus.d_valid, bus.m_req}, {61'h0, 3'b110});
    idle_inputs();
    @(negedge clk);
    check("tmo_err_1cyc", {62'h0, bus.err, bus.d_valid}, 64'h0);

    // reset in the middle of a data access
    bus.d_rd    = 1'b1;
    bus.d_addr  = 32'h0000_0088;
    @(negedge clk);
    check("rst_mid_grant", {63'h0, bus.m_req}, 64'h1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_abandon", {62'h0, bus.m_req, bus.d_valid}, 64'h0);
    check("rst_mid_rdata", {32'h0, bus.d_rdata}, 64'h0);
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    check("rst_mid_no_valid", {63'h0, bus.d_valid}, 64'h0);
    bus.d_rd    = 1'b1;
    bus.d_addr  = 32'h0000_0090;
    bus.m_rdata = 32'h1357_9BDF;
    bus.m_ready = 1'b1;
    q_d.push_back('{32'h1357_9BDF, 1'b0});
    @(negedge clk);
    check("post_rst_grant", {bus.m_req, bus.m_we, bus.m_addr}, {1'b1, 1'b0, 32'h0000_0090});
    @(negedge clk);
    check("post_rst_valid", {63'h0, bus.d_valid}, 64'h1);
    idle_inputs();
    repeat (2) @(negedge clk);

    check("scoreboard_drain", {32'(q_if.size()), 32'(q_d.size())}, 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
